// File: rtl/ptr_ll_queue_pkg.sv
// Shared types for the pointer linked-list chain (request generator and queue).
package ptr_ll_pkg;

  localparam int n     = 256;
  localparam int w_ptr = $clog2(n);

  typedef logic [w_ptr-1:0] ptr_t;
  typedef logic [w_ptr:0]   cnt_t;

endpackage

// File: rtl/ptr_ll_queue_next_ram.sv
// Next-pointer storage: N x W_PTR, one synchronous write port and one
// asynchronous read port. Kept standalone so it can be swapped for a vendor RAM.
module ptr_ll_next_ram #(
  parameter int N     = 256,
  parameter int W_PTR = $clog2(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [W_PTR-1:0] waddr,
  input  logic [W_PTR-1:0] wdata,
  input  logic [W_PTR-1:0] raddr,
  output logic [W_PTR-1:0] rdata
);

  logic [W_PTR-1:0] mem [N];

  // Synchronous write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ptr_ll_queue.sv
// Linked-list FIFO of node pointers. The pointer value is the node address,
// next_mem[p] holds the successor of p.
// Optional duplicate-push rejection: define PTR_LL_QUEUE_DUP_CHECK_EN.
//
// Handshake: a push happens when in_vld & in_rdy, a pop when out_vld & out_rdy,
// both at the rising clock edge. in_rdy depends only on full, so there is no
// combinational path from out_rdy to in_rdy; out_vld/out_ptr come from registers.
module ptr_ll_queue
  import ptr_ll_pkg::*;
#(
  parameter int N     = n,
  parameter int W_PTR = $clog2(N),
  parameter int W_CNT = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_PTR-1:0] in_ptr,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [W_PTR-1:0] out_ptr,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [W_CNT-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             err_dup
);

  logic [W_PTR-1:0] head_q, head_d;
  logic [W_PTR-1:0] tail_q, tail_d;
  logic [W_CNT-1:0] count_q, count_d;
  logic [W_PTR-1:0] nxt_rdata;
  logic             ram_we;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             dup;
  logic             count_one;

  assign full      = (count_q == W_CNT'(N));
  assign empty     = (count_q == '0);
  assign count_one = (count_q == W_CNT'(1));
  assign in_rdy    = ~full;
  assign out_vld   = ~empty;
  assign out_ptr   = head_q;
  assign count     = count_q;

  assign push_req = in_vld & in_rdy;
  assign pop      = out_vld & out_rdy;
  assign push     = push_req & ~dup;

  ptr_ll_next_ram #(
    .N     (N),
    .W_PTR (W_PTR)
  ) u_next_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (tail_q),
    .wdata (in_ptr),
    .raddr (head_q),
    .rdata (nxt_rdata)
  );

  // List pointer and occupancy update for push / pop / push+pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ram_we  = 1'b0;
    case ({push, pop})
      2'b10: begin
        tail_d  = in_ptr;
        count_d = count_q + W_CNT'(1);
        if (empty) head_d = in_ptr;
        else       ram_we = 1'b1;
      end
      2'b01: begin
        count_d = count_q - W_CNT'(1);
        // Last node leaves: head/tail keep stale values, out_vld drops.
        if (!count_one) head_d = nxt_rdata;
      end
      2'b11: begin
        if (count_one) begin
          head_d = in_ptr;
          tail_d = in_ptr;
        end else begin
          // head != tail here, so the write and read hit different entries.
          ram_we = 1'b1;
          tail_d = in_ptr;
          head_d = nxt_rdata;
        end
      end
      default: ;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef PTR_LL_QUEUE_DUP_CHECK_EN
  logic [N-1:0] in_list_q, in_list_d;
  logic         err_dup_q, err_dup_d;

  // A pointer already in the list is a duplicate unless it is the head
  // leaving in this same cycle.
  assign dup = push_req & in_list_q[in_ptr] & ~(pop & (head_q == in_ptr));

  // Membership bitmap: clear popped head, then set pushed pointer.
  always_comb begin
    in_list_d = in_list_q;
    err_dup_d = dup;
    if (pop)  in_list_d[head_q] = 1'b0;
    if (push) in_list_d[in_ptr] = 1'b1;
  end

  // Bitmap and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_list_q <= '0;
      err_dup_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign err_dup = err_dup_q;
`else
  assign dup     = 1'b0;
  assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_ll_queue.sv
// Bench for ptr_ll_queue: directed scenarios plus random traffic, checked by a
// monitor against a queue-based reference model.
module tb_ptr_ll_queue;

  localparam int N = 256;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_ptr;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] out_ptr;
  logic         out_vld;
  logic         out_rdy;
  logic [W:0]   count;
  logic         empty;
  logic         full;
  logic         err_dup;

  ptr_ll_queue dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_ptr  (in_ptr),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .out_ptr (out_ptr),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .err_dup (err_dup)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [W-1:0] exp_q[$];
  bit           pend_push;
  logic [W-1:0] pend_ptr;
  bit           pend_dup;
  bit           exp_err;
  bit           mon_en;
  int           tests;
  int           fails;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_q(input logic [W-1:0] p);
    foreach (exp_q[i]) if (exp_q[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  // driver: commits last cycle's accepted push into the model, then drives a
  // new cycle of inputs. rnd=1 picks the pointer randomly.
  task automatic drive(input bit v, input logic [W-1:0] p, input bit r, input bit rnd);
    bit pop_m;
    bit full_m;
    bit dup_m;
    logic [W-1:0] pp;
    @(negedge clk);
    if (pend_push) exp_q.push_back(pend_ptr);
    exp_err = pend_dup;
    pp = p;
    if (rnd) begin
`ifdef PTR_LL_QUEUE_DUP_CHECK_EN
      pp = W'($urandom_range(0, 15));
`else
      pp = W'($urandom_range(0, N-1));
      for (int k = 0; k < 2000 && in_q(pp) && exp_q.size() < N; k++)
        pp = W'($urandom_range(0, N-1));
`endif
    end
    pop_m  = r && (exp_q.size() > 0);
    full_m = (exp_q.size() == N);
    dup_m  = 1'b0;
`ifdef PTR_LL_QUEUE_DUP_CHECK_EN
    dup_m  = v && !full_m && in_q(pp) && !(pop_m && exp_q[0] == pp);
`endif
    pend_push = v && !full_m && !dup_m;
    pend_ptr  = pp;
    pend_dup  = dup_m;
    in_vld    = v;
    in_ptr    = pp;
    out_rdy   = r;
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_out_vld", int'(out_vld), 0);
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_in_rdy", int'(in_rdy), 1);
    exp_q.delete();
    pend_push = 1'b0;
    pend_dup  = 1'b0;
    exp_err   = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // monitor: samples 2 time units after the falling edge, checks flags against
  // the model and pops/compares the head on each pop transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("count", int'(count), exp_q.size());
        chk("out_vld", int'(out_vld), int'(exp_q.size() != 0));
        chk("empty", int'(empty), int'(exp_q.size() == 0));
        chk("full", int'(full), int'(exp_q.size() == N));
        chk("in_rdy", int'(in_rdy), int'(exp_q.size() != N));
        chk("err_dup", int'(err_dup), int'(exp_err));
        if (exp_q.size() > 0) chk("out_ptr", int'(out_ptr), int'(exp_q[0]));
        if (out_vld && out_rdy) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_empty_model: got pop of %0d expected no pop", out_ptr);
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    tests = 0; fails = 0;
    pend_push = 0; pend_dup = 0; exp_err = 0; mon_en = 0;
    rst_n = 1'b0; in_vld = 1'b0; in_ptr = '0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_in_rdy", int'(in_rdy), 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_err_dup", int'(err_dup), 0);
    chk("rst_out_ptr", int'(out_ptr), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 5, 9, 3 held, then drained
    drive(1, 8'd5, 0, 0);
    drive(1, 8'd9, 0, 0);
    drive(1, 8'd3, 0, 0);
    drive(0, 8'd0, 0, 0);
    repeat (5) drive(0, 8'd0, 1, 0);

    // single element, then push+pop same cycle
    drive(1, 8'd7, 0, 0);
    drive(1, 8'd12, 1, 0);
    drive(0, 8'd0, 0, 0);
    drive(0, 8'd0, 1, 0);
    drive(0, 8'd0, 0, 0);

    // fill to N, rejected push at full, drain in order
    for (int i = 0; i < N; i++) drive(1, W'(i), 0, 0);
    drive(1, 8'd42, 0, 0);
    drive(1, 8'd42, 1, 0);
    for (int i = 0; i < N + 2; i++) drive(0, 8'd0, 1, 0);

    // steady stream with out_rdy held high
    for (int i = 1; i <= 30; i++) drive(1, W'(i), 1, 0);
    repeat (3) drive(0, 8'd0, 1, 0);

    // reset mid-stream with four entries, then push 8
    for (int i = 0; i < 4; i++) drive(1, W'(20 + i), 0, 0);
    drive(0, 8'd0, 0, 0);
    do_reset_mid();
    drive(1, 8'd8, 0, 0);
    drive(0, 8'd0, 0, 0);
    drive(0, 8'd0, 1, 0);
    drive(0, 8'd0, 0, 0);

`ifdef PTR_LL_QUEUE_DUP_CHECK_EN
    // duplicate rejected, then legal re-push of the departing head
    drive(1, 8'd4, 0, 0);
    drive(1, 8'd6, 0, 0);
    drive(1, 8'd4, 0, 0);
    drive(1, 8'd4, 1, 0);
    drive(0, 8'd0, 0, 0);
    repeat (4) drive(0, 8'd0, 1, 0);
`endif

    // random traffic
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 99) < 60, 8'd0, $urandom_range(0, 99) < 55, 1);

    // drain, bounded
    for (int i = 0; i < N + 8 && (exp_q.size() > 0 || pend_push); i++) drive(0, 8'd0, 1, 0);
    drive(0, 8'd0, 0, 0);
    @(negedge clk);
    #3;
    chk("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ptr_ll_queue.md
Name: ptr_ll_queue

Overview:
- Downstream consumer of the pointer request generator.
- Accepts a stream of node pointers (in_ptr / in_vld) and links them into a singly linked FIFO list kept in a next-pointer RAM indexed by pointer value.
- Exposes the list head through a valid/ready pop port.
- This is the linked-list storage stage of the demo chain. No separate data RAM: the pointer itself is the node address.

Parameters:
- N, 256, number of nodes; legal pointer values 0..N-1
- W_PTR, $clog2(N), pointer width
- W_CNT, $clog2(N)+1, occupancy counter width (must hold value N)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_ptr  in  W_PTR  pointer to append at tail
- in_vld  in  1  in_ptr valid this cycle
- in_rdy  out  1  queue can accept a push (= !full)
- out_ptr  out  W_PTR  current head pointer
- out_vld  out  1  head valid (= count != 0)
- out_rdy  in  1  consumer takes head this cycle
- count  out  W_CNT  number of linked nodes
- empty  out  1  count == 0
- full  out  1  count == N
- err_dup  out  1  one-cycle pulse on a rejected duplicate push (optional feature; tied 0 when compiled out)

Behaviour:
- State: head, tail (W_PTR regs), count (W_CNT reg), next_mem[N] (W_PTR each, no reset).
- Reset (async assert, sync-safe deassert use is caller's job): head = 0, tail = 0, count = 0. Outputs: out_vld = 0, in_rdy = 1, empty = 1, full = 0, err_dup = 0, out_ptr = 0. next_mem contents are don't-care after reset.
- push = in_vld & in_rdy; pop = out_vld & out_rdy.
- Push only:
  - next_mem[tail] <= in_ptr; tail <= in_ptr.
  - If count == 0, head <= in_ptr and next_mem is not written.
  - count <= count + 1.
- Pop only:
  - out_ptr = head, combinational from register.
  - head <= next_mem[head] (asynchronous read).
  - count <= count - 1.
  - If count == 1, head and tail hold their stale values and out_vld drops next cycle.
- Push and pop in the same cycle:
  - count unchanged.
  - If count == 1: head <= in_ptr, tail <= in_ptr, no next_mem write required.
  - If count > 1: normal push plus normal pop. The next_mem[tail] write and the next_mem[head] read address different entries, since head != tail.
- Push while count == 0 with pop asserted: pop is ignored because out_vld = 0.
- Latency: a pushed pointer appears on out_ptr with out_vld = 1 in the cycle after the push when the queue was empty. FIFO order is strict.
- Full: in_rdy = 0 and in_vld is ignored. Push with pop at full is not accepted, because in_rdy depends only on full (no combinational path from out_rdy to in_rdy).
- Duplicate pointer already in the list: corrupts the list when the feature is off. This is the caller's contract.
- Reset mid-operation empties the list immediately; pointers in flight are lost.
- All arithmetic is unsigned. count never wraps: push at full and pop at empty are blocked.

Optional Feature:
- Macro: PTR_LL_QUEUE_DUP_CHECK_EN.
- Defined:
  - Adds an N-bit in_list bitmap, reset to 0. It is set on accepted push and cleared on pop.
  - If in_vld & in_rdy & in_list[in_ptr] (after accounting for a same-cycle pop of that pointer), the push is dropped: no state change and err_dup = 1 for one cycle.
  - A same-cycle pop of the identical pointer makes the push legal.
- Undefined: no bitmap, err_dup constant 0, duplicates undetected.

Decomposition:
- Package ptr_ll_pkg:
  - localparams n = 256 and w_ptr = $clog2(n)
  - typedef ptr_t (logic [w_ptr-1:0]) and cnt_t (logic [w_ptr:0]), shared with the request generator.
- One sub-module: ptr_ll_next_ram. It holds N x W_PTR with 1 sync write port and 1 async read port, so it can be remapped to vendor RAM later.

Test Plan:
- Reset, then push 5, 9, 3 on consecutive cycles with out_rdy = 0 -> count = 3, out_ptr = 5. Then out_rdy = 1 -> out_ptr sequence 5, 9, 3, then out_vld = 0, empty = 1.
- Single element 7 queued, then same-cycle push 12 and pop -> pop returns 7, next cycle out_ptr = 12, count = 1.
- N = 256: push 0..255 -> full = 1, in_rdy = 0. Push of 42 is ignored, count stays 256. Pop all -> 0..255 in order.
- Steady stream 1..30 with out_rdy = 1 every cycle -> each pointer exits one cycle after entry, count never exceeds 1.
- Assert rst_n = 0 mid-stream with count = 4 -> asynchronously count = 0, out_vld = 0. Push 8 after release -> out_ptr = 8 next cycle.
- With PTR_LL_QUEUE_DUP_CHECK_EN: push 4, 6, then 4 -> err_dup = 1 for one cycle, count = 2. Pop 4 with same-cycle push 4 -> accepted, err_dup = 0, order is 6, 4.
